// File: rtl/gimli_lwc_segment_arbiter_if.sv
// Stream bundle between the pdi/sdi requesters, the segment arbiter and the
// Gimli LWC input buffer. slave = arbiter side, master = requesters/buffer side.
interface gimli_lwc_segment_arbiter_if #(
    parameter int G_WIDTH = 32
);
    logic [G_WIDTH-1:0] pdi_data;
    logic               pdi_valid;
    logic               pdi_ready;
    logic [G_WIDTH-1:0] sdi_data;
    logic               sdi_valid;
    logic               sdi_ready;
    logic [G_WIDTH-1:0] dout;
    logic               dout_valid;
    logic               dout_ready;
    logic               dout_src;
    logic               dout_hdr;
    logic               dout_last;

    modport slave (
        input  pdi_data, pdi_valid, sdi_data, sdi_valid, dout_ready,
        output pdi_ready, sdi_ready, dout, dout_valid, dout_src, dout_hdr, dout_last
    );

    modport master (
        output pdi_data, pdi_valid, sdi_data, sdi_valid, dout_ready,
        input  pdi_ready, sdi_ready, dout, dout_valid, dout_src, dout_hdr, dout_last
    );
endinterface

// File: rtl/gimli_lwc_segment_arbiter.sv
// Segment-granular round-robin arbiter: grants pdi or sdi for one header plus
// its data words and passes the granted stream through with zero latency.
module gimli_lwc_segment_arbiter #(
    parameter int G_WIDTH     = 32,
    parameter int G_LEN_LSB   = 0,
    parameter int G_LEN_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    gimli_lwc_segment_arbiter_if.slave     s,
    output logic                           busy
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   grant_q, grant_d;
    logic                   last_grant_q, last_grant_d;
    logic [G_LEN_WIDTH-1:0] cnt_q, cnt_d;

    logic [G_WIDTH-1:0]     sel_data;
    logic                   sel_valid;
    logic                   hs;
    logic [G_LEN_WIDTH-1:0] len;

    always_comb begin
        sel_data  = grant_q ? s.sdi_data  : s.pdi_data;
        sel_valid = grant_q ? s.sdi_valid : s.pdi_valid;
        hs        = sel_valid & s.dout_ready;
        len       = sel_data[G_LEN_LSB +: G_LEN_WIDTH];

        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;

        s.pdi_ready  = 1'b0;
        s.sdi_ready  = 1'b0;
        s.dout       = '0;
        s.dout_valid = 1'b0;
        s.dout_hdr   = 1'b0;
        s.dout_last  = 1'b0;
        s.dout_src   = grant_q;
        busy         = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                // A tie goes to whoever did not finish the previous segment.
                if (s.pdi_valid && s.sdi_valid) begin
                    grant_d = ~last_grant_q;
                    state_d = ST_HEADER;
                end else if (s.pdi_valid) begin
                    grant_d = 1'b0;
                    state_d = ST_HEADER;
                end else if (s.sdi_valid) begin
                    grant_d = 1'b1;
                    state_d = ST_HEADER;
                end
            end
            ST_HEADER: begin
                s.dout       = sel_data;
                s.dout_valid = sel_valid;
                s.pdi_ready  = ~grant_q & s.dout_ready;
                s.sdi_ready  = grant_q & s.dout_ready;
                s.dout_hdr   = 1'b1;
                s.dout_last  = (len == '0) & sel_valid;
                if (hs) begin
                    if (len == '0) begin
                        last_grant_d = grant_q;
                        state_d      = ST_IDLE;
                    end else begin
                        cnt_d   = len;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                s.dout       = sel_data;
                s.dout_valid = sel_valid;
                s.pdi_ready  = ~grant_q & s.dout_ready;
                s.sdi_ready  = grant_q & s.dout_ready;
                s.dout_last  = (cnt_q == G_LEN_WIDTH'(1));
                if (hs) begin
                    cnt_d = cnt_q - G_LEN_WIDTH'(1);
                    if (cnt_q == G_LEN_WIDTH'(1)) begin
                        last_grant_d = grant_q;
                        state_d      = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Reset forces every output low, independent of state and inputs.
        if (!rst) begin
            s.pdi_ready  = 1'b0;
            s.sdi_ready  = 1'b0;
            s.dout       = '0;
            s.dout_valid = 1'b0;
            s.dout_hdr   = 1'b0;
            s.dout_last  = 1'b0;
            s.dout_src   = 1'b0;
            busy         = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end
endmodule

// File: tb/tb_gimli_lwc_segment_arbiter.sv
// Bench for gimli_lwc_segment_arbiter: directed scenarios plus a randomized
// run scored against a segment-level round-robin model.
module tb_gimli_lwc_segment_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;
    int   checks = 0;
    int   failures = 0;

    gimli_lwc_segment_arbiter_if #(.G_WIDTH(32)) bus ();

    gimli_lwc_segment_arbiter #(.G_WIDTH(32), .G_LEN_LSB(0), .G_LEN_WIDTH(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .s    (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    logic [31:0] pq[$];
    logic [31:0] sq[$];
    bit          phd[$];
    bit          shd[$];

    function automatic logic [31:0] hdr(input int l);
        logic [15:0] up;
        up = 16'($urandom);
        return {up, 16'(l)};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.pdi_valid = 1'b0; bus.sdi_valid = 1'b0;
        bus.pdi_data = '0; bus.sdi_data = '0; bus.dout_ready = 1'b0;
        pq.delete(); sq.delete(); phd.delete(); shd.delete();
        cyc(); cyc();
        rst = 1'b1;
    endtask

    // Present queue fronts; data words (never headers) may be randomly withheld.
    task automatic drive_q(input bit gaps);
        bus.pdi_valid = (pq.size() > 0) && (phd[0] || !gaps || $urandom_range(3) != 0);
        bus.pdi_data  = (pq.size() > 0) ? pq[0] : 32'h0;
        bus.sdi_valid = (sq.size() > 0) && (shd[0] || !gaps || $urandom_range(3) != 0);
        bus.sdi_data  = (sq.size() > 0) ? sq[0] : 32'h0;
    endtask

    task automatic pop_q();
        if (bus.pdi_valid && bus.pdi_ready) begin void'(pq.pop_front()); void'(phd.pop_front()); end
        if (bus.sdi_valid && bus.sdi_ready) begin void'(sq.pop_front()); void'(shd.pop_front()); end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.pdi_valid = 1'b1; bus.sdi_valid = 1'b1;
        bus.pdi_data = 32'hDEAD0003; bus.sdi_data = 32'hBEEF0002; bus.dout_ready = 1'b1;
        cyc(); cyc(); #3;
        checks++;
        if ({bus.pdi_ready, bus.sdi_ready, bus.dout_valid, bus.dout_hdr, bus.dout_last, busy, bus.dout_src} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl: pr=%b sr=%b dv=%b hdr=%b last=%b busy=%b src=%b required all 0",
                     bus.pdi_ready, bus.sdi_ready, bus.dout_valid, bus.dout_hdr, bus.dout_last, busy, bus.dout_src);
        end
        checks++;
        if (bus.dout !== 32'h0) begin
            failures++;
            $display("FAIL reset_dout: dout=%h required 0", bus.dout);
        end
    endtask

    task automatic test_single_pdi();
        logic [31:0] h;
        logic [31:0] ed[5];
        do_reset();
        h = hdr(2);
        pq = '{h, 32'hA1, 32'hA2}; phd = '{1'b1, 1'b0, 1'b0};
        ed = '{32'h0, h, 32'hA1, 32'hA2, 32'h0};
        for (int i = 0; i < 5; i++) begin
            drive_q(1'b0); bus.dout_ready = 1'b1; #3;
            checks++;
            if (i == 0 || i == 4) begin
                if (busy !== 1'b0 || bus.dout_valid !== 1'b0 || bus.pdi_ready !== 1'b0 || bus.sdi_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL single_pdi_idle c%0d: busy=%b dv=%b pr=%b sr=%b required 0", i, busy, bus.dout_valid, bus.pdi_ready, bus.sdi_ready);
                end
            end else if (busy !== 1'b1 || bus.dout_valid !== 1'b1 || bus.dout !== ed[i] || bus.dout_src !== 1'b0 ||
                         bus.dout_hdr !== (i == 1) || bus.dout_last !== (i == 3) || bus.pdi_ready !== 1'b1 || bus.sdi_ready !== 1'b0) begin
                failures++;
                $display("FAIL single_pdi_beat c%0d: dout=%h src=%b hdr=%b last=%b pr=%b sr=%b required dout=%h src=0 hdr=%b last=%b pr=1 sr=0",
                         i, bus.dout, bus.dout_src, bus.dout_hdr, bus.dout_last, bus.pdi_ready, bus.sdi_ready, ed[i], i == 1, i == 3);
            end
            pop_q(); cyc();
        end
    endtask

    task automatic test_tie();
        logic [31:0] hp1, hp2, hs1, hs2;
        logic [31:0] ed[13];
        bit eb[13];
        bit es[13];
        do_reset();
        hp1 = hdr(1); hp2 = hdr(1); hs1 = hdr(1); hs2 = hdr(1);
        pq = '{hp1, 32'hB1, hp2, 32'hB2}; phd = '{1'b1, 1'b0, 1'b1, 1'b0};
        sq = '{hs1, 32'hC1, hs2, 32'hC2}; shd = '{1'b1, 1'b0, 1'b1, 1'b0};
        eb = '{0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0};
        es = '{0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
        ed = '{32'h0, hs1, 32'hC1, 32'h0, hp1, 32'hB1, 32'h0, hs2, 32'hC2, 32'h0, hp2, 32'hB2, 32'h0};
        for (int i = 0; i < 13; i++) begin
            drive_q(1'b0); bus.dout_ready = 1'b1; #3;
            checks++;
            if (!eb[i]) begin
                if (busy !== 1'b0 || bus.dout_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL tie_idle c%0d: busy=%b dv=%b required 0", i, busy, bus.dout_valid);
                end
            end else if (busy !== 1'b1 || bus.dout_valid !== 1'b1 || bus.dout !== ed[i] || bus.dout_src !== es[i]) begin
                failures++;
                $display("FAIL tie_beat c%0d: busy=%b dv=%b dout=%h src=%b required busy=1 dv=1 dout=%h src=%b",
                         i, busy, bus.dout_valid, bus.dout, bus.dout_src, ed[i], es[i]);
            end
            pop_q(); cyc();
        end
    endtask

    task automatic test_zero_len();
        logic [31:0] h1, h2;
        logic [31:0] ed[5];
        do_reset();
        h1 = hdr(0); h2 = hdr(0);
        sq = '{h1, h2}; shd = '{1'b1, 1'b1};
        ed = '{32'h0, h1, 32'h0, h2, 32'h0};
        for (int i = 0; i < 5; i++) begin
            drive_q(1'b0); bus.dout_ready = 1'b1; #3;
            checks++;
            if (i % 2 == 0) begin
                if (busy !== 1'b0 || bus.dout_valid !== 1'b0 || bus.sdi_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL zero_len_idle c%0d: busy=%b dv=%b sr=%b required 0", i, busy, bus.dout_valid, bus.sdi_ready);
                end
            end else if (bus.dout !== ed[i] || bus.dout_hdr !== 1'b1 || bus.dout_last !== 1'b1 || bus.dout_src !== 1'b1 || bus.sdi_ready !== 1'b1) begin
                failures++;
                $display("FAIL zero_len_beat c%0d: dout=%h hdr=%b last=%b src=%b sr=%b required dout=%h hdr=1 last=1 src=1 sr=1",
                         i, bus.dout, bus.dout_hdr, bus.dout_last, bus.dout_src, bus.sdi_ready, ed[i]);
            end
            pop_q(); cyc();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] h;
        logic [31:0] ed[10];
        bit rdy[10];
        bit eb[10];
        do_reset();
        h = hdr(3);
        pq = '{h, 32'hD1, 32'hD2, 32'hD3}; phd = '{1'b1, 1'b0, 1'b0, 1'b0};
        rdy = '{1, 1, 1, 0, 0, 0, 0, 1, 1, 1};
        eb  = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        ed  = '{32'h0, h, 32'hD1, 32'hD2, 32'hD2, 32'hD2, 32'hD2, 32'hD2, 32'hD3, 32'h0};
        for (int i = 0; i < 10; i++) begin
            drive_q(1'b0); bus.dout_ready = rdy[i]; #3;
            checks++;
            if (!eb[i]) begin
                if (busy !== 1'b0 || bus.dout_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL backpressure_idle c%0d: busy=%b dv=%b required 0", i, busy, bus.dout_valid);
                end
            end else if (busy !== 1'b1 || bus.dout_valid !== 1'b1 || bus.dout !== ed[i] || bus.dout_hdr !== (i == 1) ||
                         bus.dout_last !== (i == 8) || bus.pdi_ready !== rdy[i]) begin
                failures++;
                $display("FAIL backpressure_beat c%0d: dout=%h hdr=%b last=%b pr=%b required dout=%h hdr=%b last=%b pr=%b",
                         i, bus.dout, bus.dout_hdr, bus.dout_last, bus.pdi_ready, ed[i], i == 1, i == 8, rdy[i]);
            end
            pop_q(); cyc();
        end
        checks++;
        if (pq.size() != 0) begin
            failures++;
            $display("FAIL backpressure_drain: %0d pdi words left, required 0", pq.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] hsd;
        do_reset();
        hsd = hdr(0);
        pq = '{hdr(3), 32'hE1, 32'hE2, 32'hE3}; phd = '{1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            drive_q(1'b0); bus.dout_ready = 1'b1; #3; pop_q(); cyc();
        end
        sq = '{hsd}; shd = '{1'b1};
        rst = 1'b0;
        drive_q(1'b0); #3;
        checks++;
        if ({bus.pdi_ready, bus.sdi_ready, bus.dout_valid, busy} !== 4'b0) begin
            failures++;
            $display("FAIL reset_mid_during: pr=%b sr=%b dv=%b busy=%b required 0", bus.pdi_ready, bus.sdi_ready, bus.dout_valid, busy);
        end
        pop_q(); cyc();
        rst = 1'b1;
        drive_q(1'b0); #3;
        checks++;
        if ({bus.pdi_ready, bus.sdi_ready, bus.dout_valid, busy} !== 4'b0) begin
            failures++;
            $display("FAIL reset_mid_after: pr=%b sr=%b dv=%b busy=%b required 0", bus.pdi_ready, bus.sdi_ready, bus.dout_valid, busy);
        end
        pop_q(); cyc();
        drive_q(1'b0); #3;
        checks++;
        if (busy !== 1'b1 || bus.dout_src !== 1'b1 || bus.dout !== hsd || bus.dout_last !== 1'b1 || bus.pdi_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_regrant: busy=%b src=%b dout=%h last=%b pr=%b required busy=1 src=1 dout=%h last=1 pr=0",
                     busy, bus.dout_src, bus.dout, bus.dout_last, bus.pdi_ready, hsd);
        end
        pop_q(); cyc();
    endtask

    task automatic test_max_len();
        int bad;
        bad = 0;
        do_reset();
        bus.dout_ready = 1'b1;
        bus.pdi_valid = 1'b1; bus.pdi_data = 32'h1234FFFF;
        cyc(); #3;
        checks++;
        if (bus.dout_hdr !== 1'b1 || bus.dout_last !== 1'b0 || bus.pdi_ready !== 1'b1) begin
            failures++;
            $display("FAIL max_len_hdr: hdr=%b last=%b pr=%b required hdr=1 last=0 pr=1", bus.dout_hdr, bus.dout_last, bus.pdi_ready);
        end
        cyc();
        for (int i = 1; i <= 65535; i++) begin
            bus.pdi_data = 32'(i); #3;
            checks++;
            if (bus.dout_last !== (i == 65535) || bus.dout !== 32'(i) || bus.dout_valid !== 1'b1) begin
                failures++;
                if (bad < 5) $display("FAIL max_len_word %0d: dout=%h last=%b dv=%b required dout=%h last=%b dv=1",
                                      i, bus.dout, bus.dout_last, bus.dout_valid, 32'(i), i == 65535);
                bad++;
            end
            cyc();
        end
        bus.pdi_valid = 1'b0; #3;
        checks++;
        if (busy !== 1'b0 || bus.dout_valid !== 1'b0) begin
            failures++;
            $display("FAIL max_len_end: busy=%b dv=%b required 0", busy, bus.dout_valid);
        end
    endtask

    task automatic test_random();
        int plen[$];
        int slen[$];
        logic [31:0] pcp[$];
        logic [31:0] scp[$];
        logic [31:0] e_data[$];
        bit e_src[$];
        bit e_hdr[$];
        bit e_last[$];
        bit lastg;
        bit pick;
        bit pending_idle;
        bit src_hs;
        bit other_rdy;
        int n;
        int l;
        int cycles;
        do_reset();
        for (int s = 0; s < 2; s++) begin
            n = $urandom_range(8, 15);
            for (int k = 0; k < n; k++) begin
                l = $urandom_range(0, 5);
                if (s == 0) begin plen.push_back(l); pq.push_back(hdr(l)); phd.push_back(1'b1); end
                else        begin slen.push_back(l); sq.push_back(hdr(l)); shd.push_back(1'b1); end
                for (int j = 0; j < l; j++) begin
                    if (s == 0) begin pq.push_back($urandom); phd.push_back(1'b0); end
                    else        begin sq.push_back($urandom); shd.push_back(1'b0); end
                end
            end
        end
        // Whole-segment round-robin: alternate while both have work, else take the one that does.
        pcp = pq; scp = sq; lastg = 1'b0;
        while (plen.size() > 0 || slen.size() > 0) begin
            pick = (plen.size() > 0 && slen.size() > 0) ? !lastg : (slen.size() > 0);
            l = pick ? slen.pop_front() : plen.pop_front();
            for (int k = 0; k <= l; k++) begin
                e_data.push_back(pick ? scp.pop_front() : pcp.pop_front());
                e_src.push_back(pick); e_hdr.push_back(k == 0); e_last.push_back(k == l);
            end
            lastg = pick;
        end
        pending_idle = 1'b1;
        cycles = 0;
        while (e_data.size() > 0 && cycles < 5000) begin
            drive_q(1'b1); bus.dout_ready = ($urandom_range(3) != 0); #3;
            checks++;
            if (pending_idle) begin
                if (busy !== 1'b0 || bus.dout_valid !== 1'b0 || bus.pdi_ready !== 1'b0 || bus.sdi_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL random_idle cyc%0d: busy=%b dv=%b pr=%b sr=%b required 0", cycles, busy, bus.dout_valid, bus.pdi_ready, bus.sdi_ready);
                end
                pending_idle = 1'b0;
            end else if (busy !== 1'b1) begin
                failures++;
                $display("FAIL random_busy cyc%0d: busy=%b required 1", cycles, busy);
            end
            if (bus.dout_valid === 1'b1 && bus.dout_ready) begin
                src_hs    = e_src[0] ? (bus.sdi_valid & bus.sdi_ready) : (bus.pdi_valid & bus.pdi_ready);
                other_rdy = e_src[0] ? bus.pdi_ready : bus.sdi_ready;
                checks++;
                if (bus.dout !== e_data[0] || bus.dout_src !== e_src[0] || bus.dout_hdr !== e_hdr[0] ||
                    bus.dout_last !== e_last[0] || src_hs !== 1'b1 || other_rdy !== 1'b0) begin
                    failures++;
                    $display("FAIL random_beat cyc%0d: dout=%h src=%b hdr=%b last=%b hs=%b other_rdy=%b required dout=%h src=%b hdr=%b last=%b hs=1 other_rdy=0",
                             cycles, bus.dout, bus.dout_src, bus.dout_hdr, bus.dout_last, src_hs, other_rdy,
                             e_data[0], e_src[0], e_hdr[0], e_last[0]);
                end
                if (e_last[0]) pending_idle = 1'b1;
                void'(e_data.pop_front()); void'(e_src.pop_front());
                void'(e_hdr.pop_front()); void'(e_last.pop_front());
            end
            pop_q(); cyc();
            cycles++;
        end
        checks++;
        if (e_data.size() != 0) begin
            failures++;
            $display("FAIL random_timeout: %0d beats outstanding after %0d cycles, required 0", e_data.size(), cycles);
        end
    endtask

    initial begin
        bus.pdi_valid = 1'b0; bus.sdi_valid = 1'b0;
        bus.pdi_data = '0; bus.sdi_data = '0; bus.dout_ready = 1'b0;
        test_reset();
        test_single_pdi();
        test_tie();
        test_zero_len();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_max_len();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
